// File: rtl/seg7_capture.sv
// Captures the digit codes shown on a multiplexed active-low 7-segment bus once
// each digit's pattern has been stable for STABLE_CYCLES registered samples.
module seg7_capture #(
    parameter int unsigned STABLE_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  SEG,
    input  logic [3:0]  BITS,
    output logic [15:0] value,
    output logic [3:0]  dp,
    output logic [3:0]  digit_valid,
    output logic        frame_valid,
    output logic        err,
    output logic [1:0]  err_digit
);

    typedef enum logic [1:0] {IDLE, TRACK, HELD} state_t;

    localparam logic [3:0] STABLE = 4'(STABLE_CYCLES);

    state_t     state, state_next;
    logic [3:0] count, count_next, count_inc;
    logic [7:0] seg_q, prev_seg;
    logic [3:0] bits_q, prev_bits;
    logic [3:0] seen;
    logic       selected, same, capture;
    logic [1:0] sel_idx;
    logic [6:0] pattern;
    logic [3:0] code;
    logic       known, blank;
    logic [3:0] seen_add;

    always_comb begin
        selected = 1'b1;
        sel_idx  = 2'd0;
        unique case (bits_q)
            4'b1110: sel_idx = 2'd0;
            4'b1101: sel_idx = 2'd1;
            4'b1011: sel_idx = 2'd2;
            4'b0111: sel_idx = 2'd3;
            default: selected = 1'b0;
        endcase
    end

    assign same      = (seg_q == prev_seg) && (bits_q == prev_bits);
    assign count_inc = (count == STABLE) ? count : count + 4'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            count <= '0;
        end else begin
            state <= state_next;
            count <= count_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count;
        if (!selected) begin
            state_next = IDLE;
            count_next = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    state_next = TRACK;
                    count_next = 4'd1;
                end
                TRACK: begin
                    if (same) begin
                        count_next = count_inc;
                        if (count_inc == STABLE) state_next = HELD;
                    end else begin
                        count_next = 4'd1;
                    end
                end
                HELD: begin
                    if (!same) begin
                        state_next = TRACK;
                        count_next = 4'd1;
                    end
                end
                default: begin
                    state_next = IDLE;
                    count_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        capture = (state == TRACK) && selected && same && (count_inc == STABLE);
    end

    // Segment bus is active-low; dp is excluded from the lookup.
    assign pattern = ~seg_q[6:0];
    assign blank   = (pattern == 7'h00);

    always_comb begin
        known = 1'b1;
        code  = 4'h0;
        unique case (pattern)
            7'h3F: code = 4'h0;
            7'h06: code = 4'h1;
            7'h5B: code = 4'h2;
            7'h4F: code = 4'h3;
            7'h66: code = 4'h4;
            7'h6D: code = 4'h5;
            7'h7D: code = 4'h6;
            7'h07: code = 4'h7;
            7'h7F: code = 4'h8;
            7'h6F: code = 4'h9;
            7'h77: code = 4'hA;
            7'h7C: code = 4'hB;
            7'h39: code = 4'hC;
            7'h5E: code = 4'hD;
            7'h79: code = 4'hE;
            7'h71: code = 4'hF;
            default: known = 1'b0;
        endcase
    end

    assign seen_add = (capture && (known || blank)) ? (4'b0001 << sel_idx) : 4'b0000;

    always_ff @(posedge clk) begin
        if (rst) begin
            seg_q       <= '1;
            bits_q      <= '1;
            prev_seg    <= '1;
            prev_bits   <= '1;
            seen        <= '0;
            value       <= '0;
            dp          <= '0;
            digit_valid <= '0;
            frame_valid <= 1'b0;
            err         <= 1'b0;
            err_digit   <= '0;
        end else begin
            seg_q     <= SEG;
            bits_q    <= BITS;
            prev_seg  <= seg_q;
            prev_bits <= bits_q;
            err       <= 1'b0;
            // A full mask completes the frame one edge later; a capture on that
            // edge lands in the freshly cleared mask.
            if (seen == 4'hF) begin
                frame_valid <= 1'b1;
                seen        <= seen_add;
            end else begin
                frame_valid <= 1'b0;
                seen        <= seen | seen_add;
            end
            if (capture) begin
                if (known) begin
                    value[{sel_idx, 2'b00} +: 4] <= code;
                    dp[sel_idx]                  <= ~seg_q[7];
                    digit_valid[sel_idx]         <= 1'b1;
                end else if (blank) begin
                    value[{sel_idx, 2'b00} +: 4] <= 4'h0;
                    dp[sel_idx]                  <= ~seg_q[7];
                    digit_valid[sel_idx]         <= 1'b0;
                end else begin
                    digit_valid[sel_idx] <= 1'b0;
                    err                  <= 1'b1;
                    err_digit            <= sel_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_seg7_capture.sv
// Directed bench for seg7_capture; err/frame_valid pulses are matched against
// a queue of expected events, captured fields are checked at fixed points.
module tb_seg7_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  SEG = 8'hFF;
    logic [3:0]  BITS = 4'hF;
    logic [15:0] value;
    logic [3:0]  dp;
    logic [3:0]  digit_valid;
    logic        frame_valid;
    logic        err;
    logic [1:0]  err_digit;

    typedef struct {
        logic       err;
        logic       frame;
        logic [1:0] digit;
    } ev_t;

    ev_t sb[$];
    int  errors = 0;
    int  checks = 0;

    seg7_capture #(.STABLE_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .SEG(SEG), .BITS(BITS),
        .value(value), .dp(dp), .digit_valid(digit_valid),
        .frame_valid(frame_valid), .err(err), .err_digit(err_digit)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input logic [7:0] s, input logic [3:0] b);
        SEG  = s;
        BITS = b;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        cycles(2);
        rst = 1'b0;
    endtask

    task automatic push_ev(input logic e, input logic f, input logic [1:0] d);
        ev_t ev;
        ev.err   = e;
        ev.frame = f;
        ev.digit = d;
        sb.push_back(ev);
    endtask

    task automatic wait_dv(input logic [3:0] exp, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (digit_valid === exp) break;
            @(negedge clk);
        end
        check("wait_digit_valid", digit_valid, exp);
    endtask

    // Scoreboard consumer: every err or frame_valid pulse must match the next queued event.
    always @(negedge clk) begin
        if (err === 1'b1 || frame_valid === 1'b1) begin
            if (sb.size() == 0) begin
                check("sb_unexpected_err", err, 1'b0);
                check("sb_unexpected_frame", frame_valid, 1'b0);
            end else begin
                ev_t ev;
                ev = sb.pop_front();
                check("sb_err", err, ev.err);
                check("sb_frame", frame_valid, ev.frame);
                if (ev.err) check("sb_err_digit", err_digit, ev.digit);
            end
        end
    end

    initial begin
        @(negedge clk);
        do_reset();
        check("rst_value", value, 16'h0000);
        check("rst_dp", dp, 4'h0);
        check("rst_dv", digit_valid, 4'h0);
        check("rst_frame", frame_valid, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_err_digit", err_digit, 2'd0);

        // "3" on digit 0: exact latency, capture on the 5th edge after the bus changes
        drive(8'hB0, 4'b1110);
        cycles(4);
        check("lat_early_value", value, 16'h0000);
        cycles(1);
        check("cap3_value", value, 16'h0003);
        check("cap3_dv", digit_valid, 4'b0001);
        check("cap3_dp", dp, 4'b0000);
        cycles(4);
        check("held_dv", digit_valid, 4'b0001);
        drive(8'hFF, 4'hF);
        cycles(2);

        // Full scan; digit 0 written twice to exercise overwrite without double count
        do_reset();
        drive(8'hB0, 4'b1110); cycles(6);
        drive(8'hF9, 4'b1110); cycles(6);
        drive(8'hA4, 4'b1101); cycles(6);
        drive(8'h08, 4'b1011); cycles(6);
        check("scan_no_frame_yet", sb.size(), 0);
        push_ev(1'b0, 1'b1, 2'd0);
        drive(8'h8E, 4'b0111); cycles(6);
        drive(8'hFF, 4'hF); cycles(2);
        check("scan_value", value, 16'hFA21);
        check("scan_dp", dp, 4'b0100);
        check("scan_dv", digit_valid, 4'b1111);
        check("scan_sb_empty", sb.size(), 0);

        // Blank for 3 samples then "1" on digit 1: only the "1" is captured
        do_reset();
        drive(8'hFF, 4'b1101); cycles(3);
        drive(8'hF9, 4'b1101); cycles(1);
        check("short_hold_dv", digit_valid, 4'b0000);
        wait_dv(4'b0010, 8);
        check("late_cap_value", value, 16'h0010);

        // Blank capture on digit 0
        drive(8'hFF, 4'b1110); cycles(6);
        check("blank_value", value, 16'h0010);
        check("blank_dv", digit_valid, 4'b0010);
        check("blank_dp", dp, 4'b0000);

        // Unrecognized pattern on digit 2
        push_ev(1'b1, 1'b0, 2'd2);
        drive(8'h81, 4'b1011); cycles(6);
        check("bad_dv", digit_valid, 4'b0010);
        check("bad_value", value, 16'h0010);
        check("bad_err_digit", err_digit, 2'd2);
        check("bad_sb_empty", sb.size(), 0);

        // Two selects low: blanking, nothing changes
        drive(8'hB0, 4'b1100); cycles(10);
        check("multi_sel_value", value, 16'h0010);
        check("multi_sel_dv", digit_valid, 4'b0010);

        // Reset on the 3rd stable cycle discards the partial count
        drive(8'hB0, 4'b1110); cycles(3);
        rst = 1'b1; cycles(1); rst = 1'b0;
        check("midrst_value", value, 16'h0000);
        check("midrst_dv", digit_valid, 4'b0000);
        check("midrst_err_digit", err_digit, 2'd0);
        cycles(4);
        check("midrst_no_cap", value, 16'h0000);
        cycles(1);
        check("midrst_cap", value, 16'h0003);
        check("midrst_cap_dv", digit_valid, 4'b0001);
        cycles(2);
        check("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
